// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame state encoding, parity selectors and frame bit counts.
// Used by both the transmitter and the receiver side.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned START_BITS  = 1;
    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned PARITY_BITS = 1;
    localparam int unsigned STOP_BITS   = 1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..P-1 (prescale 0 behaves as 1) and strobes bit_done_o
// on the last cycle of each bit. The bit length is captured when restart_i is asserted.
module uart_tx_bit_timer #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      restart_i,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      bit_done_o
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] last_q, last_d;

    assign bit_done_o = enable_i && !restart_i && (cnt_q == last_q);

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (restart_i) begin
            last_d = (prescale_i == '0) ? '0 : prescale_i - 1'b1;
            cnt_d  = '0;
        end else if (enable_i) begin
            cnt_d = bit_done_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// tx_out and busy are driven straight from flops; each bit lasts prescale clock cycles.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    input  logic                      par_en,
    input  logic                      par_type,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  accept;
    logic                  bit_done;

    assign accept = (state_q == ST_IDLE) && data_valid;
    assign tx_out = tx_q;
    assign busy   = busy_q;

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk_i     (clk),
        .rst_ni    (rst),
        .restart_i (accept),
        .enable_i  (busy_q),
        .prescale_i(prescale),
        .bit_done_o(bit_done)
    );

    // The line value for the next bit is loaded on the edge that ends the current one,
    // so tx_out stays a pure flop output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_valid) begin
                        shift_q   <= p_data;
                        par_en_q  <= par_en;
                        par_bit_q <= (par_type == PAR_ODD) ? ~^p_data : ^p_data;
                        idx_q     <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                            if (par_en_q) begin
                                tx_q    <= par_bit_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, hand-written corner sequences and
// random frames compared against a bit-position model of the serial frame.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] p_data = '0;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_type = 1'b0;
    logic [5:0] prescale = '0;
    logic       tx_out;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_WIDTH    (8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_en    (par_en),
        .par_type  (par_type),
        .prescale  (prescale),
        .tx_out    (tx_out),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic [5:0] ps;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: frame described as a list of bit values, each held P cycles.
    function automatic int model_len(input logic pe, input logic [5:0] ps);
        int p;
        p = (ps == 0) ? 1 : int'(ps);
        return (pe ? 11 : 10) * p;
    endfunction

    function automatic logic model_parity(input logic [7:0] d, input logic pt);
        logic even_bit;
        even_bit = (($countones(d) % 2) != 0);
        return pt ? ~even_bit : even_bit;
    endfunction

    function automatic logic model_bit(input logic [7:0] d, input logic pe, input logic par, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (pe && k == 9) return par;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", int'(n >= 2000), 0);
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps, input logic exp_par, input int exp_len,
                             input int inject_at);
        int p;
        int tx_bad;
        int busy_bad;
        p = (ps == 0) ? 1 : int'(ps);
        tx_bad = 0;
        busy_bad = 0;
        wait_idle();
        @(negedge clk);
        p_data = d; par_en = pe; par_type = pt; prescale = ps; data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        p_data = 8'($urandom); par_en = 1'($urandom); par_type = 1'($urandom); prescale = 6'($urandom);
        for (int c = 0; c < exp_len; c++) begin
            @(negedge clk);
            if (tx_out !== model_bit(d, pe, exp_par, c / p)) tx_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (c == inject_at) begin
                p_data = 8'h11;
                data_valid = 1'b1;
                @(posedge clk);
                #1;
                data_valid = 1'b0;
            end
        end
        @(negedge clk);
        check({name, "_tx_bad_cycles"}, tx_bad, 0);
        check({name, "_busy_low_in_frame"}, busy_bad, 0);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_tx_end"}, tx_out, 1);
    endtask

    initial begin
        vec_t vecs[7];
        int   idle_bad;
        int   starts[4];
        int   nst;
        int   gap_ok;
        logic prev_tx;
        logic prev_busy;
        logic [7:0] rd;
        logic rpe, rpt;
        logic [5:0] rps;

        vecs[0] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, ps: 6'd8,  exp_par: 1'b0, exp_len: 88};
        vecs[1] = '{data: 8'h37, pe: 1'b1, pt: 1'b1, ps: 6'd16, exp_par: 1'b0, exp_len: 176};
        vecs[2] = '{data: 8'h00, pe: 1'b0, pt: 1'b0, ps: 6'd32, exp_par: 1'b0, exp_len: 320};
        vecs[3] = '{data: 8'hFF, pe: 1'b1, pt: 1'b0, ps: 6'd8,  exp_par: 1'b0, exp_len: 88};
        vecs[4] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, ps: 6'd1,  exp_par: 1'b1, exp_len: 11};
        vecs[5] = '{data: 8'h80, pe: 1'b1, pt: 1'b1, ps: 6'd0,  exp_par: 1'b0, exp_len: 11};
        vecs[6] = '{data: 8'h3C, pe: 1'b1, pt: 1'b1, ps: 6'd63, exp_par: 1'b1, exp_len: 693};

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", tx_out, 1);
        check("reset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tx", tx_out, 1);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 7; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].ps,
                      vecs[i].exp_par, vecs[i].exp_len, -1);

        // Request while busy must be dropped; line then stays idle.
        run_frame("ignore_busy", 8'hFF, 1'b1, 1'b0, 6'd8, 1'b0, 88, 40);
        idle_bad = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        check("ignore_busy_idle_after", idle_bad, 0);

        // Asynchronous reset mid-frame (during a low data bit).
        wait_idle();
        @(negedge clk);
        p_data = 8'h5A; par_en = 1'b1; par_type = 1'b0; prescale = 6'd8; data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_tx", tx_out, 1);
        check("rst_async_busy", busy, 0);
        idle_bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        check("rst_hold_idle", idle_bad, 0);
        @(negedge clk);
        rst = 1'b1;
        run_frame("after_rst", 8'h5A, 1'b1, 1'b0, 6'd8, 1'b0, 88, -1);

        // data_valid held high: starts every 11*P+1 cycles, each after an idle-high cycle.
        wait_idle();
        @(negedge clk);
        prev_tx = tx_out;
        prev_busy = busy;
        p_data = 8'($urandom); par_en = 1'b1; par_type = 1'($urandom); prescale = 6'd8; data_valid = 1'b1;
        nst = 0;
        gap_ok = 1;
        starts = '{0, 0, 0, 0};
        for (int c = 0; c < 267; c++) begin
            @(negedge clk);
            if (busy === 1'b1 && prev_busy === 1'b0) begin
                if (nst < 4) starts[nst] = c;
                nst++;
                if (!(prev_tx === 1'b1 && tx_out === 1'b0)) gap_ok = 0;
            end
            prev_tx = tx_out;
            prev_busy = busy;
        end
        data_valid = 1'b0;
        check("b2b_start_count", nst, 3);
        check("b2b_gap1", starts[1] - starts[0], 89);
        check("b2b_gap2", starts[2] - starts[1], 89);
        check("b2b_idle_before_start", gap_ok, 1);

        for (int i = 0; i < 24; i++) begin
            rd  = 8'($urandom);
            rpe = 1'($urandom);
            rpt = 1'($urandom);
            rps = 6'($urandom_range(0, 7));
            run_frame($sformatf("rand%0d", i), rd, rpe, rpt, rps, model_parity(rd, rpt),
                      model_len(rpe, rps), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, counterpart of the existing `uartRx_top` receiver. It accepts one parallel byte plus frame configuration, then serializes a start bit, 8 data bits LSB-first, an optional parity bit and a stop bit onto `tx_out`. It runs on the same oversampled clock as the receiver, and each bit lasts `prescale` clock cycles, so TX and RX can be looped back on a single clock.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame.
- `PRESCALE_WIDTH`, 6: width of the `prescale` input and of the cycle counter.
- `clk`  in  1: oversampled clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `p_data`  in  DATA_WIDTH: byte to send; sampled only on the accept edge.
- `data_valid`  in  1: send request; honoured only when `busy` = 0.
- `par_en`  in  1: 1 inserts a parity bit; sampled on the accept edge.
- `par_type`  in  1: 0 even, 1 odd; sampled on the accept edge.
- `prescale`  in  PRESCALE_WIDTH: clock cycles per bit; sampled on the accept edge.
- `tx_out`  out  1: serial line, idles high.
- `busy`  out  1: high while a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx_out` = 1, `busy` = 0.
- Accept edge: a rising edge in IDLE with `data_valid` = 1.
  - On that edge the block latches `p_data`, `par_en`, `par_type` and `prescale`.
  - It computes parity from the latched byte: even = ^data, odd = ~^data.
  - It moves to START and sets `tx_out` = 0 and `busy` = 1.
- Cycle counter: counts 0..P-1, where P is the latched `prescale`. `prescale` = 0 is treated as 1. When the count reaches P-1 the current bit ends, the counter wraps to 0 and the state advances.
- START advances to DATA with bit index 0.
- DATA drives data[index]. After index 7 it goes to PARITY if `par_en` = 1, otherwise to STOP.
- PARITY drives the parity bit, then goes to STOP.
- STOP drives 1. On its last cycle the block returns to IDLE and `busy` = 0 on that edge.
- `data_valid` while `busy` = 1 is ignored. There is no queueing.
- Input changes mid-frame have no effect on the frame in progress.
- Reset (asserted at any time, including mid-frame) forces IDLE, `tx_out` = 1, `busy` = 0, and zeroes all counters. The partial frame is abandoned, with no glitch low after reset.

## Timing
- Reset values: `tx_out` = 1, `busy` = 0.
- Latency: `tx_out` falls on the accept edge itself, since it is a registered output.
- Frame length is 11·P cycles with parity, 10·P without. `busy` is high for exactly that many cycles.
- Bit k of the frame (start = 0) occupies cycles [k·P, (k+1)·P) after the accept edge.
- Back-to-back transfers: earliest next accept is the first edge with `busy` = 0. This adds at least one idle-high cycle, so the stop bit is effectively ≥ P+1 cycles.
- Holding `data_valid` high continuously gives a new frame every 11·P+1 cycles with parity.
- `tx_out` and `busy` come directly from flops, with no combinational path from inputs.

## Structure
- Shared package holds:
  - the state enumeration (IDLE/START/DATA/PARITY/STOP, 3-bit encoding);
  - the parity type constants EVEN = 0 and ODD = 1;
  - the frame bit-count constants.
  The RX side reuses the same package.
- One natural sub-module, `uart_tx_bit_timer`: the prescale cycle counter with a `bit_done` strobe and a restart on the accept edge. The FSM, shift/index logic and parity all stay in `uart_tx`.

## Test plan
- Prescale 8, par_en = 1, even, `p_data` = 0xA5 -> `tx_out` over 88 cycles gives the bits 0, 1,0,1,0,0,1,0,1, 0, 1, each held 8 cycles. `busy` is high 88 cycles, then 0.
- Prescale 16, par_en = 1, odd, 0x37 -> parity bit 0 (five ones). Frame 176 cycles. Loopback into `uartRx_top` with the same settings yields p_data = 0x37 and data_valid = 1.
- Prescale 32, par_en = 0, 0x00 -> 9 bits low (start plus data), each held 32 cycles, then high. `busy` is high 320 cycles.
- Pulse `data_valid` with 0x11 while busy, 40 cycles into a 0xFF frame at prescale 8 -> 0x11 is never sent. After `busy` falls, the line stays high until a new request.
- `rst` low at cycle 30 of a frame -> `tx_out` = 1 and `busy` = 0 immediately (asynchronously). The next request with 0x5A produces a clean full frame.
- `data_valid` held high for 3 frames at prescale 8 with parity -> consecutive start bits 89 cycles apart, each preceded by ≥ 1 idle-high cycle.
